// File: rtl/dsp_spi_frontend.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dsp_spi_frontend
//  Description : SPI slave front-end (mode 0) for the dsp block. All SPI pins
//                are oversampled in the i_CLK domain. Host write payloads are
//                deserialised into a one-byte holding register. Each byte is
//                handed to dsp as a one-cycle o_SPI_VALID strobe once one of
//                the dsp ack flags is high. The result snapshot or a status
//                byte is serialised back to the host on MISO.
//  Ports       : i_CLK, i_RST          - system clock, sync active-high reset
//                i_SPI_SCK/CS_N/MOSI   - host SPI pins (asynchronous)
//                o_SPI_MISO            - slave data out, MSB first
//                o_SPI_VALID/o_SPI_DATA- byte strobe and zero-extended byte
//                i_*_ACK               - dsp ready flags
//                i_RESULT              - dsp accumulate result
//  Commands    : 0x01 write byte, 0x02 read result, 0x03 read status
//  Revision    : 1.0 - initial release
// ============================================================================
module dsp_spi_frontend #(
  parameter int BUS_WIDTH    = 32,
  parameter int DATA_WIDTH   = 8,
  parameter int OUTPUT_WIDTH = 32
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic                    i_SPI_SCK,
  input  logic                    i_SPI_CS_N,
  input  logic                    i_SPI_MOSI,
  output logic                    o_SPI_MISO,
  output logic                    o_SPI_VALID,
  output logic [BUS_WIDTH-1:0]    o_SPI_DATA,
  input  logic                    i_WEIGHT_ACK,
  input  logic                    i_DATA_ACK,
  input  logic                    i_CONV_ACK,
  input  logic [OUTPUT_WIDTH-1:0] i_RESULT
);

  localparam int                 c_CNT_W     = $clog2(OUTPUT_WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_CMD_LAST  = c_CNT_W'(7);
  localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_ST_LAST   = c_CNT_W'(7);
  localparam logic [c_CNT_W-1:0] c_CNT_SAT   = c_CNT_W'(OUTPUT_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CMD      = 3'd1,
    S_WR_DATA  = 3'd2,
    S_RD_SHIFT = 3'd3,
    S_ST_SHIFT = 3'd4,
    S_IGNORE   = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // Pin synchronisers. The third SCK/CS flop gives edge detection. CS resets
  // high so a frame already in progress across reset is not picked up halfway.
  // --------------------------------------------------------------------------
  logic [2:0] r_sck_sync;
  logic [2:0] r_cs_sync;
  logic [1:0] r_mosi_sync;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_sck_sync  <= 3'b000;
      r_cs_sync   <= 3'b111;
      r_mosi_sync <= 2'b00;
    end else begin
      r_sck_sync  <= {r_sck_sync[1:0], i_SPI_SCK};
      r_cs_sync   <= {r_cs_sync[1:0], i_SPI_CS_N};
      r_mosi_sync <= {r_mosi_sync[0], i_SPI_MOSI};
    end
  end

  logic w_sck_rise, w_sck_fall, w_cs_n, w_cs_fall, w_mosi;
  assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
  assign w_sck_fall = ~r_sck_sync[1] & r_sck_sync[2];
  assign w_cs_n     = r_cs_sync[1];
  assign w_cs_fall  = ~r_cs_sync[1] & r_cs_sync[2];
  assign w_mosi     = r_mosi_sync[1];

  // --------------------------------------------------------------------------
  // Datapath / FSM state
  // --------------------------------------------------------------------------
  state_t                  r_state;
  logic [c_CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0]   r_shift_in;
  logic [OUTPUT_WIDTH-1:0] r_shift_out;
  logic [DATA_WIDTH-1:0]   r_hold;
  logic                    r_pending;
  logic                    r_ovf;
  logic                    r_miso;
  logic                    r_valid;
  logic [BUS_WIDTH-1:0]    r_data;

  logic [DATA_WIDTH-1:0]   w_shift_next;
  logic [7:0]              w_status;
  logic                    w_issue;

  assign w_shift_next = {r_shift_in[DATA_WIDTH-2:0], w_mosi};
  assign w_status     = {4'b0000, r_ovf, i_CONV_ACK, i_DATA_ACK, i_WEIGHT_ACK};
  // The ~r_valid term guarantees a idle cycle between strobes so the dsp ack
  // has time to drop before another byte can be issued.
  assign w_issue      = r_pending & (i_WEIGHT_ACK | i_DATA_ACK | i_CONV_ACK) & ~r_valid;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shift_in  <= '0;
      r_shift_out <= '0;
      r_hold      <= '0;
      r_pending   <= 1'b0;
      r_ovf       <= 1'b0;
      r_miso      <= 1'b0;
      r_valid     <= 1'b0;
      r_data      <= '0;
    end else begin
      // Issue path runs independently of the SPI framing.
      r_valid <= w_issue;
      if (w_issue) begin
        r_data    <= BUS_WIDTH'(r_hold);
        r_pending <= 1'b0;
      end

      if (w_cs_n) begin
        // Deselect aborts whatever is in flight; partial bytes are lost.
        r_state   <= S_IDLE;
        r_bit_cnt <= '0;
        r_miso    <= 1'b0;
      end else if (w_cs_fall) begin
        r_state   <= S_CMD;
        r_bit_cnt <= '0;
        r_miso    <= 1'b0;
      end else begin
        case (r_state)
          S_CMD: begin
            if (w_sck_rise) begin
              r_shift_in <= w_shift_next;
              if (r_bit_cnt == c_CMD_LAST) begin
                r_bit_cnt <= '0;
                case (w_shift_next[7:0])
                  8'h01: r_state <= S_WR_DATA;
                  8'h02: begin
                    r_state     <= S_RD_SHIFT;
                    r_shift_out <= i_RESULT;
                    r_miso      <= i_RESULT[OUTPUT_WIDTH-1];
                  end
                  8'h03: begin
                    r_state     <= S_ST_SHIFT;
                    r_shift_out <= OUTPUT_WIDTH'(w_status) << (OUTPUT_WIDTH - 8);
                    r_miso      <= w_status[7];
                  end
                  default: r_state <= S_IGNORE;
                endcase
              end else begin
                r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
              end
            end
          end

          S_WR_DATA: begin
            if (w_sck_rise) begin
              r_shift_in <= w_shift_next;
              if (r_bit_cnt == c_DATA_LAST) begin
                r_bit_cnt <= '0;
                r_state   <= S_CMD;
                // A byte leaving on this same cycle frees the holding register.
                if (!r_pending || w_issue) begin
                  r_hold    <= w_shift_next;
                  r_pending <= 1'b1;
                end else begin
                  r_ovf <= 1'b1;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
              end
            end
          end

          S_RD_SHIFT, S_ST_SHIFT: begin
            // r_bit_cnt counts host sample edges. The MSB is already on MISO
            // from the decode cycle, so the fall before the first sample edge
            // must not advance the register. Once everything is shifted out
            // the register holds zeros and MISO idles low.
            if (w_sck_rise) begin
              if (r_bit_cnt != c_CNT_SAT)
                r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
              if (r_state == S_ST_SHIFT && r_bit_cnt == c_ST_LAST)
                r_ovf <= 1'b0;
            end else if (w_sck_fall && r_bit_cnt != '0) begin
              r_shift_out <= {r_shift_out[OUTPUT_WIDTH-2:0], 1'b0};
              r_miso      <= r_shift_out[OUTPUT_WIDTH-2];
            end
          end

          default: begin
            // IDLE and IGNORE: MISO stays low until the next frame.
            r_miso <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_SPI_MISO  = r_miso;
  assign o_SPI_VALID = r_valid;
  assign o_SPI_DATA  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_dsp_spi_frontend.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dsp_spi_frontend
//  Description : Directed self-checking bench for dsp_spi_frontend. Expected
//                write bytes go into a scoreboard queue when driven and are
//                popped by a monitor on each o_SPI_VALID strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_spi_frontend;

  localparam int HALF = 8;  // SCK half period in i_CLK cycles (f_SCK = f_CLK/16)

  logic        clk = 1'b0;
  logic        rst;
  logic        sck, cs_n, mosi;
  logic        miso, valid;
  logic [31:0] data;
  logic        wack, dack, cack;
  logic [31:0] result;

  always #5 clk = ~clk;

  dsp_spi_frontend #(
    .BUS_WIDTH   (32),
    .DATA_WIDTH  (8),
    .OUTPUT_WIDTH(32)
  ) dut (
    .i_CLK       (clk),
    .i_RST       (rst),
    .i_SPI_SCK   (sck),
    .i_SPI_CS_N  (cs_n),
    .i_SPI_MOSI  (mosi),
    .o_SPI_MISO  (miso),
    .o_SPI_VALID (valid),
    .o_SPI_DATA  (data),
    .i_WEIGHT_ACK(wack),
    .i_DATA_ACK  (dack),
    .i_CONV_ACK  (cack),
    .i_RESULT    (result)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pulse = 0;
  logic [31:0] sb[$];
  logic        prev_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected byte and
  // must never follow another strobe directly.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      n_pulse++;
      check("valid_not_back_to_back", {31'd0, prev_valid}, 32'd0);
      check("valid_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) check("valid_data", data, sb.pop_front());
    end
    prev_valid = valid;
  end

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      repeat (HALF) @(negedge clk);
      rx  = {rx[6:0], miso};
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  logic [7:0]  rx;
  logic [31:0] word;
  int          p0;

  initial begin
    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    wack = 1'b0; dack = 1'b0; cack = 1'b0; result = 32'h0;
    repeat (4) @(negedge clk);
    check("reset_miso",  {31'd0, miso},  32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_data",  data,           32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: single write with weight ack already high
    wack = 1'b1;
    p0 = n_pulse;
    sb.push_back(32'h0000_00A5);
    cs_begin();
    spi_bits(8'h01, 8, rx);
    spi_bits(8'hA5, 8, rx);   // pulse lands well inside the trailing half period
    check("wr1_pulse_count", n_pulse - p0, 32'd1);
    check("wr1_sb_drained",  sb.size(),    32'd0);
    cs_end();
    check("wr1_no_extra", n_pulse - p0, 32'd1);
    wack = 1'b0;

    // 2: write with acks low, ack raised later
    p0 = n_pulse;
    sb.push_back(32'h0000_003C);
    cs_begin();
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h3C, 8, rx);
    cs_end();
    repeat (50) @(negedge clk);
    check("wr2_none_before_ack", n_pulse - p0, 32'd0);
    dack = 1'b1;
    @(negedge clk);
    check("wr2_valid_after_ack", {31'd0, valid}, 32'd1);
    repeat (3) @(negedge clk);
    dack = 1'b0;
    check("wr2_pulse_count", n_pulse - p0, 32'd1);

    // 3: second write while pending -> dropped, ovf in status
    p0 = n_pulse;
    sb.push_back(32'h0000_0011);
    cs_begin();
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h11, 8, rx);
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h22, 8, rx);
    cs_end();
    cs_begin();
    spi_bits(8'h03, 8, rx);
    spi_bits(8'h00, 8, rx);
    cs_end();
    check("status_ovf", {24'd0, rx}, 32'h08);
    cs_begin();
    spi_bits(8'h03, 8, rx);
    spi_bits(8'h00, 8, rx);
    cs_end();
    check("status_ovf_cleared", {24'd0, rx}, 32'h00);
    check("ovf_no_pulse_yet", n_pulse - p0, 32'd0);
    wack = 1'b1;
    repeat (10) @(negedge clk);
    check("ovf_one_pulse", n_pulse - p0, 32'd1);
    check("ovf_sb_drained", sb.size(), 32'd0);
    wack = 1'b0;

    // 4: result read, snapshot immune to later changes, zeros afterwards
    result = 32'hDEAD_BEEF;
    cs_begin();
    spi_bits(8'h02, 8, rx);
    word = '0;
    for (int b = 0; b < 4; b++) begin
      if (b == 2) result = 32'h1234_5678;
      spi_bits(8'h00, 8, rx);
      word = {word[23:0], rx};
    end
    check("rd_word", word, 32'hDEAD_BEEF);
    spi_bits(8'h00, 8, rx);
    check("rd_trailing_zero", {24'd0, rx}, 32'h00);
    cs_end();

    // 5: aborted write, then a normal one
    wack = 1'b1;
    p0 = n_pulse;
    cs_begin();
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h77, 5, rx);
    cs_end();
    repeat (20) @(negedge clk);
    check("abort_no_pulse", n_pulse - p0, 32'd0);
    sb.push_back(32'h0000_005A);
    cs_begin();
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h5A, 8, rx);
    cs_end();
    check("after_abort_pulse", n_pulse - p0, 32'd1);
    wack = 1'b0;

    // 6: reset in the middle of a result read
    result = 32'hFFFF_FFFF;
    cs_begin();
    spi_bits(8'h02, 8, rx);
    spi_bits(8'h00, 4, rx);
    check("pre_reset_miso", {31'd0, miso}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_miso",  {31'd0, miso},  32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_data",  data,           32'd0);
    sck = 1'b0; cs_n = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    wack = 1'b1; dack = 1'b0; cack = 1'b1;
    cs_begin();
    spi_bits(8'h03, 8, rx);
    spi_bits(8'h00, 8, rx);
    cs_end();
    check("status_after_reset", {24'd0, rx}, 32'h05);
    check("no_stray_pulses", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
